dmem_subword: RTL
=================

DMEM_SUBWORD -- requirements
Module: dmem_subword

Interface
REQ-001 Parameter ADDR_BITS, default 10, byte-address width; memory depth is 2^ADDR_BITS bytes.
REQ-002 Parameter LATENCY, default 1, legal range 1..15, cycles from request acceptance to response.
REQ-003 Parameter BIG_ENDIAN, default 1; 1 = lowest address holds most-significant byte, 0 = lowest address holds least-significant byte.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 0 byte, 1 half (2B), 2 word (4B), 3 double (8B).
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  64  byte address; only [ADDR_BITS-1:0] used.
REQ-012 req_wdata  in  64  store data; the low (size) bytes are used.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  64  load result, extended to 64 bits; 0 for stores and faults.
REQ-016 rsp_misaligned  out  1  request faulted on alignment; valid with rsp_valid.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 On an edge with req_valid && req_ready, the block SHALL capture write/size/unsigned/addr/wdata, load a counter with LATENCY-1, and enter WAIT.
REQ-019 In WAIT, the counter SHALL decrement each edge; on the edge where it is 0, the access SHALL be performed and the state SHALL become RESP, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 A request SHALL be misaligned when addr mod (1<<size) != 0; misaligned requests SHALL neither write memory nor read it, and SHALL respond with rsp_misaligned = 1 and rsp_rdata = 0 after the same latency.
REQ-021 An aligned store SHALL write exactly (1<<size) bytes at addr..addr+(1<<size)-1 in the byte order set by BIG_ENDIAN; other bytes are untouched.
REQ-022 An aligned load SHALL assemble (1<<size) bytes in the BIG_ENDIAN order and sign- or zero-extend them per req_unsigned; for size 3 req_unsigned has no effect.
REQ-023 Address bits above ADDR_BITS-1 SHALL be ignored (aliasing); aligned accesses never cross the top of memory.
REQ-024 In RESP, rsp_valid, rsp_rdata, and rsp_misaligned SHALL hold stable until an edge with rsp_ready = 1, which SHALL return the state to IDLE; the next request may be accepted no earlier than the following edge.
REQ-025 req_valid while not in IDLE SHALL be ignored; no request queueing.
REQ-026 Store responses SHALL carry rsp_rdata = 0 and rsp_misaligned = 0 when aligned.
REQ-027 Minimum request-to-request spacing SHALL be LATENCY+2 cycles with rsp_ready held at 1.

Reset
REQ-028 While reset is high, the state SHALL be IDLE, the counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_misaligned = 0, regardless of clk.
REQ-029 Reset SHALL NOT clear memory contents; memory SHALL be all-zero at time zero only.
REQ-030 Reset asserted during WAIT SHALL discard the pending request; a pending store SHALL NOT reach memory.
REQ-031 Reset asserted during RESP SHALL drop the response without a handshake.

Verification
REQ-032 Store double 0x0123456789ABCDEF @0x10, BIG_ENDIAN=1, then load byte @0x10 unsigned -> rsp_rdata 0x01; load half @0x16 -> 0x...CDEF sign-extended = 0xFFFFFFFFFFFFCDEF.
REQ-033 Store word 0x80000000 @0x20, then load word @0x20 signed -> 0xFFFFFFFF80000000; unsigned -> 0x0000000080000000; bytes 0x24..0x27 stay 0.
REQ-034 Load word @0x21 -> rsp_misaligned=1, rsp_rdata=0; store half @0x33 of 0xBEEF -> misaligned, later load byte @0x33 = 0.
REQ-035 LATENCY=4: accept at edge N -> rsp_valid first high after edge N+4; hold rsp_ready=0 for 3 cycles -> response stable, req_ready=0, extra req_valid ignored.
REQ-036 Store double @0x40 accepted, reset pulsed in WAIT -> outputs at reset values immediately, later load @0x40 returns 0.
REQ-037 ADDR_BITS=10: store byte 0xAA @0x400 -> load byte @0x000 unsigned returns 0xAA (alias).

Source files
------------

// File: rtl/dmem_subword.sv
// Byte-addressable data memory with sub-word loads/stores, fixed response latency,
// and selectable endianness. Storage is organised as 8-byte lines with byte enables.
module dmem_subword #(
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 1,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_misaligned
);

  localparam int         LINES    = 1 << (ADDR_BITS - 3);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic                   misal_q, misal_d;

  logic [2:0]             req_mask;
  logic                   access_en;
  logic [3:0]             nbytes;
  logic [2:0]             off;
  logic [2:0]             lane;
  logic [7:0]             lane_we;
  logic [63:0]            lane_wdata;
  logic [63:0]            rd_line_q;
  logic [63:0]            load_raw;
  logic [63:0]            load_value;
  logic                   sign_bit;
  logic                   ext_bit;
  logic                   unused_addr_hi;

  logic [63:0] mem [LINES] = '{default: '0};

  assign unused_addr_hi = ^req_addr[63:ADDR_BITS];

  always_comb begin
    case (req_size)
      2'd0:    req_mask = 3'b000;
      2'd1:    req_mask = 3'b001;
      2'd2:    req_mask = 3'b011;
      default: req_mask = 3'b111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    misal_d = misal_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_BITS-1:0];
          wdata_d = req_wdata;
          misal_d = |(req_addr[2:0] & req_mask);
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      misal_q <= misal_d;
    end
  end

  // The access fires on the last WAIT edge; aligned accesses never straddle an 8-byte line.
  assign access_en = (state_q == WAIT) && (cnt_q == 4'd0) && !misal_q;

  // Value byte i maps to lane off+i (little) or off+n-1-i (big).
  always_comb begin
    nbytes     = 4'd1 << size_q;
    off        = addr_q[2:0];
    lane       = 3'd0;
    lane_we    = '0;
    lane_wdata = '0;
    load_raw   = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        lane = off + (BIG_ENDIAN ? 3'(nbytes - 4'd1 - 4'(i)) : 3'(i));
        lane_we[lane]           = access_en && write_q;
        lane_wdata[8*lane +: 8] = wdata_q[8*i +: 8];
        load_raw[8*i +: 8]      = rd_line_q[8*lane +: 8];
      end
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    sign_bit = load_raw[7];
      2'd1:    sign_bit = load_raw[15];
      2'd2:    sign_bit = load_raw[31];
      default: sign_bit = load_raw[63];
    endcase
    ext_bit    = !uns_q && sign_bit;
    load_value = load_raw;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) >= nbytes) load_value[8*i +: 8] = {8{ext_bit}};
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 8; l++) begin
      if (lane_we[l]) mem[addr_q[ADDR_BITS-1:3]][8*l +: 8] <= lane_wdata[8*l +: 8];
    end
    if (access_en) rd_line_q <= mem[addr_q[ADDR_BITS-1:3]];
  end

  // Read line is held from the access edge, so the assembled result is stable through RESP.
  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_misaligned = (state_q == RESP) && misal_q;
  assign rsp_rdata      = ((state_q == RESP) && !write_q && !misal_q) ? load_value : 64'd0;

endmodule
